// File: rtl/register_file.sv
// register_file: 8 x 16-bit general-purpose register file for the CPU core.
// Two combinational read ports, one synchronous write port, and a fixed tap on R7.
// Reset is asynchronous and clears every register, including R0 and R7.
module register_file #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] rs_addr,
   input  logic [ADDR_WIDTH-1:0] rt_addr,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [DATA_WIDTH-1:0] rs_data,
   output logic [DATA_WIDTH-1:0] rt_data,
   output logic [DATA_WIDTH-1:0] r7_data
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LINK_REG = ADDR_WIDTH'(7);

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

   // Storage: reset wins over write; a write lands on the rising edge only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (write) begin
         r_regs[rd_addr] <= data;
      end
   end

   // Read ports: zero-latency, no write bypass, so a same-address read shows the old value until the edge.
   always_comb begin
      rs_data = r_regs[rs_addr];
      rt_data = r_regs[rt_addr];
      r7_data = r_regs[LINK_REG];
   end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed, self-checking bench for register_file.
module tb_register_file;

   logic        clock;
   logic        reset;
   logic        write;
   logic [2:0]  rs_addr;
   logic [2:0]  rt_addr;
   logic [2:0]  rd_addr;
   logic [15:0] data;
   logic [15:0] rs_data;
   logic [15:0] rt_data;
   logic [15:0] r7_data;

   int n_tests;
   int n_fail;

   register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
      .clock   (clock),
      .reset   (reset),
      .write   (write),
      .rs_addr (rs_addr),
      .rt_addr (rt_addr),
      .rd_addr (rd_addr),
      .data    (data),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .r7_data (r7_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; performs one write on the next rising edge and returns at the following falling edge.
   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      write   = 1'b1;
      rd_addr = a;
      data    = d;
      @(posedge clock);
      @(negedge clock);
      write   = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      write   = 1'b0;
      rs_addr = 3'd0;
      rt_addr = 3'd0;
      rd_addr = 3'd0;
      data    = 16'h0000;

      // Reset state
      repeat (2) @(negedge clock);
      rs_addr = 3'd3;
      rt_addr = 3'd5;
      #1;
      check("reset_rs", rs_data, 16'h0000);
      check("reset_rt", rt_data, 16'h0000);
      check("reset_r7", r7_data, 16'h0000);
      @(negedge clock);
      reset = 1'b0;

      // R0 and R7 are both writable
      wr(3'd0, 16'h0001);
      wr(3'd7, 16'h00AB);
      rs_addr = 3'd0;
      rt_addr = 3'd7;
      #1;
      check("wr_r0_rs", rs_data, 16'h0001);
      check("wr_r7_rt", rt_data, 16'h00AB);
      check("wr_r7_tap", r7_data, 16'h00AB);

      // Hold with write=0 while data toggles to all ones
      write   = 1'b0;
      data    = 16'hFFFF;
      rd_addr = 3'd0;
      repeat (3) @(negedge clock);
      #1;
      check("hold_rs", rs_data, 16'h0001);
      check("hold_rt", rt_data, 16'h00AB);
      check("hold_r7", r7_data, 16'h00AB);

      // Read-during-write on the same address: no bypass
      wr(3'd3, 16'h0033);
      rs_addr = 3'd3;
      rt_addr = 3'd3;
      rd_addr = 3'd3;
      data    = 16'h1234;
      write   = 1'b1;
      #1;
      check("rdw_before", rs_data, 16'h0033);
      @(posedge clock);
      #1;
      check("rdw_after_rs", rs_data, 16'h1234);
      check("rdw_after_rt", rt_data, 16'h1234);
      @(negedge clock);
      write = 1'b0;

      // Fill every register with 0x1000+i and sweep both read ports
      for (int i = 0; i < 8; i++) begin
         wr(3'(i), 16'h1000 + 16'(i));
      end
      for (int i = 0; i < 8; i++) begin
         rs_addr = 3'(i);
         rt_addr = 3'(7 - i);
         #1;
         check($sformatf("sweep_rs%0d", i), rs_data, 16'h1000 + 16'(i));
         check($sformatf("sweep_rt%0d", 7 - i), rt_data, 16'h1000 + 16'(7 - i));
      end
      check("sweep_r7", r7_data, 16'h1007);

      // Asynchronous reset mid-run: outputs clear with no clock edge
      @(negedge clock);
      rs_addr = 3'd1;
      rt_addr = 3'd2;
      #1;
      check("pre_areset_rs", rs_data, 16'h1001);
      reset = 1'b1;
      #1;
      check("areset_rs", rs_data, 16'h0000);
      check("areset_rt", rt_data, 16'h0000);
      check("areset_r7", r7_data, 16'h0000);

      // Write coincident with reset is dropped
      write   = 1'b1;
      rd_addr = 3'd2;
      data    = 16'hBEEF;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      write = 1'b0;
      rs_addr = 3'd2;
      #1;
      check("wr_during_reset", rs_data, 16'h0000);
      check("wr_during_reset_r7", r7_data, 16'h0000);

      // Registers are usable again once reset is released
      wr(3'd2, 16'hBEEF);
      #1;
      check("post_reset_wr", rs_data, 16'hBEEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, expected finish before 100000");
      $fatal(1);
   end

endmodule
